tri_pixel_collector: RTL and testbench
======================================

# tri_pixel_collector

Downstream stage of the triangle rasterizer. Captures the rasterizer's pixel stream (`po`/`xo`/`yo`, framed by `busy`) into an 8x8 coverage bitmap. When the triangle completes, it drains the bitmap row by row over a valid/ready interface. It also gates the rasterizer's `nt` so a new triangle cannot start until the drain finishes.

## Interface
Parameters:
- `W`, 3: coordinate width; bitmap is 2^W x 2^W (only 3 is verified).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `busy_i`, in, 1: rasterizer busy.
- `po_i`, in, 1: pixel valid from the rasterizer.
- `xo_i`, in, 3: pixel x.
- `yo_i`, in, 3: pixel y.
- `accept_o`, out, 1: high only in IDLE; upstream ANDs this with `nt`.
- `row_valid`, out, 1: row beat valid.
- `row_ready`, in, 1: consumer ready.
- `row_idx`, out, 3: row number (y) of the current beat.
- `row_data`, out, 8: bit x set means pixel (x, row_idx) is covered.
- `row_last`, out, 1: high with row 7.
- `done`, out, 1: one-cycle pulse after the final row transfers.
- `dup_err`, out, 1: sticky per triangle; a pixel was reported twice.
- `pix_cnt`, out, 7: distinct pixels captured; present only with `TPC_PIXCNT_EN`.

## Operation
State machine: IDLE, COLLECT, DRAIN.

IDLE
- `accept_o`=1.
- On `busy_i`=1:
  - clear the bitmap, `dup_err` and `pix_cnt`;
  - go to COLLECT;
  - a `po_i` present in this same cycle is captured into the freshly cleared map.

COLLECT
- Each cycle with `po_i`=1:
  - if bit `[yo_i][xo_i]` is clear, set it and increment `pix_cnt`;
  - if the bit is already set, set `dup_err` and leave the count unchanged.
- On `busy_i`=0, go to DRAIN. A `po_i`=1 in that same cycle is still captured, so the final pixel coincident with busy falling is never lost.

DRAIN
- Row pointer starts at 0.
- `row_valid`=1, `row_data` = bitmap row `row_idx`.
- On `row_valid`&`row_ready`, advance the pointer.
- On row 7, `row_last`=1. After its transfer: pulse `done`, go to IDLE.
- `busy_i` and `po_i` are ignored in DRAIN; `accept_o`=0 prevents them legally.

Arithmetic
- `pix_cnt` saturates at 64; it cannot exceed 64 without a duplicate.
- Coordinates are used unsigned, with no range check at W=3.

Reset (asynchronous, any state, including mid-collect or mid-drain)
- state=IDLE, bitmap=0, row pointer=0.
- `row_valid`=0, `row_last`=0, `done`=0, `dup_err`=0, `pix_cnt`=0, `accept_o`=1.

## Timing
- All outputs are registered, except `accept_o` and `row_data`, which are decoded from state and registers with no input paths.
- A pixel sampled at edge N is visible in the bitmap and count after edge N.
- `busy_i` seen low at edge N: `row_valid` is high from edge N+1.
- With `row_ready` tied high:
  - the drain takes 8 cycles;
  - `done` is high the cycle after the row-7 handshake;
  - `accept_o` rises in the same cycle as `done`.
- Under backpressure, `row_idx`, `row_data` and `row_last` hold stable while `row_valid`&!`row_ready`.
- `row_valid` never drops without a handshake, except on reset.
- Minimum triangle-to-triangle turnaround: COLLECT end + 9 cycles.

## Configuration
- `TPC_PIXCNT_EN` defined: the `pix_cnt` port, counter and saturation logic exist.
- Undefined: the port and counter are removed.
  - `dup_err` remains, since it is driven directly from the bitmap bit test.
  - All other behaviour and timing are identical.

## Structure
- Shared package `tri_pkg`:
  - coordinate width constant (`TRI_W`=3);
  - state enum `tpc_state_t` {IDLE, COLLECT, DRAIN};
  - row-data typedef (`logic [7:0]`).
- One sub-module, `tpc_bitmap`: 8x8 flop array with synchronous clear, set-by-(x,y) port, hit flag (bit already set) and row-read mux.
- FSM and handshake logic stay in the top module.

## Test plan
- **Basic triangle.** Pixels (0,0),(1,0),(2,0),(0,1),(1,1),(0,2), then `busy_i` falls with `row_ready`=1. Required: rows 0..7 = 0x07, 0x03, 0x01, 0x00 x5; `row_last` on row 7; `done` one cycle later; `pix_cnt`=6; `dup_err`=0.
- **Last pixel at busy fall.** `po_i`=1 with (7,7) in the same cycle `busy_i`=0. Required: row 7 = 0x80 and the pixel is counted.
- **Backpressure.** `row_ready` low for 3 cycles on row 2. Required: `row_idx`=2 and `row_data` are held, with no skipped or repeated rows.
- **Duplicate pixel.** (3,4) sent twice. Required: `dup_err`=1 until the next triangle starts; `pix_cnt`=1; row 4 = 0x08.
- **Back-to-back triangles.** `busy_i` pulsed again during DRAIN. Required: ignored; `accept_o`=0 until `done`. A second triangle afterwards starts from a cleared bitmap.
- **Reset mid-operation.** `reset` asserted mid-COLLECT and separately mid-DRAIN. Required: all outputs go to their reset values immediately; the next triangle drains correctly.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle pixel collector.
// Holds the coordinate width, the collector state encoding and the row type.
package tri_pkg;

    localparam int TRI_W       = 3;
    localparam int TRI_N       = 1 << TRI_W;
    localparam int TPC_PIX_MAX = TRI_N * TRI_N;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } tpc_state_t;

    typedef logic [TRI_N-1:0] tpc_row_t;

endpackage

// File: rtl/tri_pixel_collector_if.sv
// Row stream between the collector and its downstream consumer.
// The master (collector) drives valid/idx/data/last; the slave drives ready.
interface tri_pixel_collector_if
    import tri_pkg::*;
#(
    parameter int W = TRI_W
) ();

    logic                row_valid;
    logic                row_ready;
    logic [W-1:0]        row_idx;
    logic [(1<<W)-1:0]   row_data;
    logic                row_last;

    modport master (
        output row_valid,
        output row_idx,
        output row_data,
        output row_last,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_idx,
        input  row_data,
        input  row_last,
        output row_ready
    );

endinterface

// File: rtl/tpc_bitmap.sv
// Coverage bitmap for the collector: a 2^W x 2^W flop array.
// Supports a synchronous clear, a set-by-(x,y) write, a "bit already set"
// hit flag for the addressed pixel, and a row-read mux for draining.
module tpc_bitmap
    import tri_pkg::*;
#(
    parameter int W = TRI_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_set,
    input  logic [W-1:0]        i_x,
    input  logic [W-1:0]        i_y,
    input  logic [W-1:0]        i_row_sel,
    output logic                o_hit,
    output logic [(1<<W)-1:0]   o_row_data
);

    localparam int N = 1 << W;

    logic [N-1:0][N-1:0] r_map;

    // Clear and set may coincide: the set lands in the freshly cleared map.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_map <= '0;
        end else begin
            if (i_clear) begin
                r_map <= '0;
            end
            if (i_set) begin
                r_map[i_y][i_x] <= 1'b1;
            end
        end
    end

    // A map being cleared this cycle holds nothing, so it can never report a hit.
    assign o_hit      = !i_clear && r_map[i_y][i_x];
    assign o_row_data = r_map[i_row_sel];

endmodule

// File: rtl/tri_pixel_collector.sv
// Downstream stage of the triangle rasterizer.
// Captures the pixel stream framed by busy_i into an 8x8 coverage bitmap,
// then drains it row by row over a valid/ready stream. accept_o is high only
// while idle so the upstream can hold off the next triangle until the drain ends.
// Optional feature macro: TPC_PIXCNT_EN adds the pix_cnt port and its
// saturating distinct-pixel counter.
module tri_pixel_collector
    import tri_pkg::*;
#(
    parameter int W = TRI_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         busy_i,
    input  logic                         po_i,
    input  logic [W-1:0]                 xo_i,
    input  logic [W-1:0]                 yo_i,
    output logic                         accept_o,
    tri_pixel_collector_if.master        row_if,
    output logic                         done,
    output logic                         dup_err
`ifdef TPC_PIXCNT_EN
    ,
    output logic [2*W:0]                 pix_cnt
`endif
);

    localparam int N = 1 << W;

    tpc_state_t         r_state;
    tpc_state_t         w_nextState;
    logic               w_accept;

    logic [W-1:0]       r_rowPtr;
    logic               r_rowValid;
    logic               r_rowLast;
    logic               r_done;
    logic               r_dupErr;

    logic               w_start;
    logic               w_capture;
    logic               w_enterDrain;
    logic               w_hit;
    logic               w_handshake;
    logic               w_finalBeat;
    logic [N-1:0]       w_rowData;

    assign w_start      = (r_state == IDLE) && busy_i;
    assign w_capture    = po_i && (w_start || (r_state == COLLECT));
    assign w_enterDrain = (r_state == COLLECT) && !busy_i;
    assign w_handshake  = r_rowValid && row_if.row_ready;
    assign w_finalBeat  = w_handshake && r_rowLast;

    tpc_bitmap #(
        .W          (W)
    ) u_bitmap (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start),
        .i_set      (w_capture),
        .i_x        (xo_i),
        .i_y        (yo_i),
        .i_row_sel  (r_rowPtr),
        .o_hit      (w_hit),
        .o_row_data (w_rowData)
    );

    // State register for the collect/drain sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; accept_o depends on state alone so it has no input path.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = 1'b1;
                if (busy_i) begin
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (!busy_i) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_finalBeat) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Row stream: valid rises with the entry into DRAIN and only falls after row 7 transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rowPtr   <= '0;
            r_rowValid <= 1'b0;
            r_rowLast  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finalBeat;
            if (w_enterDrain) begin
                r_rowPtr   <= '0;
                r_rowValid <= 1'b1;
                r_rowLast  <= 1'b0;
            end else if (w_handshake) begin
                r_rowPtr  <= r_rowPtr + 1'b1;
                r_rowLast <= (r_rowPtr == W'(N-2));
                if (r_rowLast) begin
                    r_rowValid <= 1'b0;
                end
            end
        end
    end

    // Duplicate flag is sticky for the whole triangle and only cleared when the next one starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dupErr <= 1'b0;
        end else if (w_start) begin
            r_dupErr <= 1'b0;
        end else if (w_capture && w_hit) begin
            r_dupErr <= 1'b1;
        end
    end

`ifdef TPC_PIXCNT_EN
    localparam logic [2*W:0] PIX_MAX = (2*W+1)'(N*N);

    logic [2*W:0] r_pixCnt;

    // Counts distinct pixels; a pixel captured on the start cycle seeds the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixCnt <= '0;
        end else if (w_start) begin
            r_pixCnt <= (2*W+1)'(w_capture);
        end else if (w_capture && !w_hit && (r_pixCnt != PIX_MAX)) begin
            r_pixCnt <= r_pixCnt + 1'b1;
        end
    end

    assign pix_cnt = r_pixCnt;
`endif

    assign accept_o         = w_accept;
    assign done             = r_done;
    assign dup_err          = r_dupErr;
    assign row_if.row_valid = r_rowValid;
    assign row_if.row_idx   = r_rowPtr;
    assign row_if.row_data  = w_rowData;
    assign row_if.row_last  = r_rowLast;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed bench for tri_pixel_collector.
// Covers reset state, a basic triangle, last pixel at busy fall, backpressure,
// duplicate pixels, busy pulsed during drain, and reset mid-collect/mid-drain.
// The pix_cnt checks are present only when TPC_PIXCNT_EN is defined.
module tb_tri_pixel_collector;

    logic       clk;
    logic       reset;
    logic       busyIn;
    logic       poIn;
    logic [2:0] xIn;
    logic [2:0] yIn;
    logic       acceptOut;
    logic       doneOut;
    logic       dupErrOut;
`ifdef TPC_PIXCNT_EN
    logic [6:0] pixCntOut;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [7:0] expRows [8];

    tri_pixel_collector_if rowIf ();

    tri_pixel_collector dut (
        .clk      (clk),
        .reset    (reset),
        .busy_i   (busyIn),
        .po_i     (poIn),
        .xo_i     (xIn),
        .yo_i     (yIn),
        .accept_o (acceptOut),
        .row_if   (rowIf),
        .done     (doneOut),
        .dup_err  (dupErrOut)
`ifdef TPC_PIXCNT_EN
        ,
        .pix_cnt  (pixCntOut)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic busy, input logic po, input logic [2:0] x, input logic [2:0] y);
        busyIn = busy;
        poIn   = po;
        xIn    = x;
        yIn    = y;
        tick();
    endtask

    task automatic clearExp();
        for (int i = 0; i < 8; i++) begin
            expRows[i] = 8'h00;
        end
    endtask

    // Walks all 8 rows, optionally stalling one row and pulsing busy during another.
    task automatic drainRows(input int stallRow, input int stallCycles, input int pulseRow);
        rowIf.row_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if (r == stallRow) begin
                rowIf.row_ready = 1'b0;
                for (int s = 0; s < stallCycles; s++) begin
                    checkOutput($sformatf("stall%0d_valid_r%0d", s, r), rowIf.row_valid, 1);
                    checkOutput($sformatf("stall%0d_idx_r%0d", s, r), rowIf.row_idx, r);
                    checkOutput($sformatf("stall%0d_data_r%0d", s, r), rowIf.row_data, expRows[r]);
                    tick();
                end
                rowIf.row_ready = 1'b1;
            end
            checkOutput($sformatf("valid_r%0d", r), rowIf.row_valid, 1);
            checkOutput($sformatf("idx_r%0d", r), rowIf.row_idx, r);
            checkOutput($sformatf("data_r%0d", r), rowIf.row_data, expRows[r]);
            checkOutput($sformatf("last_r%0d", r), rowIf.row_last, (r == 7) ? 1 : 0);
            checkOutput($sformatf("accept_r%0d", r), acceptOut, 0);
            checkOutput($sformatf("done_r%0d", r), doneOut, 0);
            if (r == pulseRow) begin
                busyIn = 1'b1;
                poIn   = 1'b1;
                xIn    = 3'd0;
                yIn    = 3'd7;
            end
            tick();
            busyIn = 1'b0;
            poIn   = 1'b0;
        end
        checkOutput("done_pulse", doneOut, 1);
        checkOutput("accept_at_done", acceptOut, 1);
        checkOutput("valid_after_drain", rowIf.row_valid, 0);
        checkOutput("last_after_drain", rowIf.row_last, 0);
        rowIf.row_ready = 1'b0;
        tick();
        checkOutput("done_clears", doneOut, 0);
    endtask

    // Directed sequence: each block is one scenario with hand-computed rows.
    initial begin
        reset           = 1'b1;
        busyIn          = 1'b0;
        poIn            = 1'b0;
        xIn             = 3'd0;
        yIn             = 3'd0;
        rowIf.row_ready = 1'b0;
        tick();
        tick();

        checkOutput("rst_accept", acceptOut, 1);
        checkOutput("rst_valid", rowIf.row_valid, 0);
        checkOutput("rst_last", rowIf.row_last, 0);
        checkOutput("rst_done", doneOut, 0);
        checkOutput("rst_dup", dupErrOut, 0);
        checkOutput("rst_idx", rowIf.row_idx, 0);
`ifdef TPC_PIXCNT_EN
        checkOutput("rst_pixcnt", pixCntOut, 0);
`endif
        reset = 1'b0;
        tick();

        $display("[TB] basic triangle");
        applyStimulus(1, 1, 0, 0);
        checkOutput("t1_accept_collect", acceptOut, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 2, 0);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(1, 1, 0, 2);
        checkOutput("t1_valid_collect", rowIf.row_valid, 0);
        rowIf.row_ready = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_dup", dupErrOut, 0);
`ifdef TPC_PIXCNT_EN
        checkOutput("t1_pixcnt", pixCntOut, 6);
`endif
        clearExp();
        expRows[0] = 8'h07;
        expRows[1] = 8'h03;
        expRows[2] = 8'h01;
        drainRows(-1, 0, -1);

        $display("[TB] last pixel at busy fall");
        applyStimulus(1, 1, 5, 5);
        rowIf.row_ready = 1'b1;
        applyStimulus(0, 1, 7, 7);
        poIn = 1'b0;
`ifdef TPC_PIXCNT_EN
        checkOutput("t2_pixcnt", pixCntOut, 2);
`endif
        clearExp();
        expRows[5] = 8'h20;
        expRows[7] = 8'h80;
        drainRows(-1, 0, -1);

        $display("[TB] backpressure on row 2");
        applyStimulus(1, 1, 4, 2);
        applyStimulus(1, 1, 6, 2);
        applyStimulus(1, 1, 1, 3);
        applyStimulus(0, 0, 0, 0);
        clearExp();
        expRows[2] = 8'h50;
        expRows[3] = 8'h02;
        drainRows(2, 3, -1);

        $display("[TB] duplicate pixel");
        applyStimulus(1, 1, 3, 4);
        checkOutput("t4_dup_first", dupErrOut, 0);
        applyStimulus(1, 1, 3, 4);
        checkOutput("t4_dup_second", dupErrOut, 1);
        applyStimulus(0, 0, 0, 0);
`ifdef TPC_PIXCNT_EN
        checkOutput("t4_pixcnt", pixCntOut, 1);
`endif
        clearExp();
        expRows[4] = 8'h08;
        drainRows(-1, 0, -1);
        checkOutput("t4_dup_sticky", dupErrOut, 1);

        $display("[TB] busy pulsed during drain");
        applyStimulus(1, 1, 7, 0);
        checkOutput("t5_dup_cleared", dupErrOut, 0);
        applyStimulus(0, 0, 0, 0);
        clearExp();
        expRows[0] = 8'h80;
        drainRows(-1, 0, 3);
        checkOutput("t5_accept_idle", acceptOut, 1);

        $display("[TB] reset mid-collect");
        applyStimulus(1, 1, 1, 1);
        applyStimulus(1, 1, 1, 1);
        checkOutput("t6_dup_before_rst", dupErrOut, 1);
        busyIn = 1'b0;
        poIn   = 1'b0;
        reset  = 1'b1;
        #2;
        checkOutput("t6_rst_accept", acceptOut, 1);
        checkOutput("t6_rst_dup", dupErrOut, 0);
        checkOutput("t6_rst_valid", rowIf.row_valid, 0);
        checkOutput("t6_rst_done", doneOut, 0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1, 1, 6, 6);
        applyStimulus(0, 0, 0, 0);
`ifdef TPC_PIXCNT_EN
        checkOutput("t6_pixcnt", pixCntOut, 1);
`endif
        clearExp();
        expRows[6] = 8'h40;
        drainRows(-1, 0, -1);

        $display("[TB] reset mid-drain");
        applyStimulus(1, 1, 3, 3);
        rowIf.row_ready = 1'b1;
        applyStimulus(0, 0, 0, 0);
        tick();
        tick();
        checkOutput("t7_idx_before_rst", rowIf.row_idx, 2);
        rowIf.row_ready = 1'b0;
        reset           = 1'b1;
        #2;
        checkOutput("t7_rst_valid", rowIf.row_valid, 0);
        checkOutput("t7_rst_idx", rowIf.row_idx, 0);
        checkOutput("t7_rst_last", rowIf.row_last, 0);
        checkOutput("t7_rst_done", doneOut, 0);
        checkOutput("t7_rst_accept", acceptOut, 1);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1, 1, 0, 5);
        applyStimulus(0, 0, 0, 0);
        clearExp();
        expRows[5] = 8'h01;
        drainRows(-1, 0, -1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
